// File: rtl/ray_generator.sv
// Camera ray generator: walks the pixel grid in raster order and emits one
// normalised ray per pixel.
// Latency: ray_valid rises 58 cycles after start accept or after the previous handshake.
// Backpressure: OUT holds every output stable until ray_ready; nothing else stalls.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start / busy       frame request (honoured in IDLE only) / frame in progress
//   ray_valid/ray_ready  ray handshake
//   ro, rd             vec3 {x,y,z} Q16.16 origin and unit direction
//   pix_x, pix_y, last pixel coordinates of the ray, last pixel of frame
//   frame_done         one-cycle pulse after the final handshake
module ray_generator #(
  parameter int          WIDTH  = 4,
  parameter int          HEIGHT = 4,
  parameter logic [31:0] INV_H  = 32'h0000_4000,
  parameter logic [31:0] CAM_X  = 32'h0000_0000,
  parameter logic [31:0] CAM_Y  = 32'h0001_0000,
  parameter logic [31:0] CAM_Z  = 32'hFFFD_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        ray_valid,
  input  logic        ray_ready,
  output logic [95:0] ro,
  output logic [95:0] rd,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        last,
  output logic        frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SQRT  = 3'd2;
  localparam logic [2:0] S_RECIP = 3'd3;
  localparam logic [2:0] S_SCALE = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]         state;
  logic [11:0]        px, py;
  logic signed [31:0] ux, uy;
  logic [47:0]        sq_rad;
  logic [25:0]        sq_rem;
  logic [23:0]        root;
  logic [23:0]        dv_rem;
  logic [31:0]        quot;
  logic [4:0]         cnt;
  logic [31:0]        rd_x, rd_y, rd_z;

  // Screen-plane coordinates of the current pixel and squared ray length.
  logic signed [31:0] dx, dy, ux_c, uy_c;
  logic signed [47:0] sqx, sqy;
  logic [31:0]        len2_c;

  // The low 48 bits of the 64-bit squares are all that survive the >>>16
  // followed by truncation to 32 bits.
  assign dx     = $signed({20'd0, px}) - 32'(WIDTH / 2);
  assign dy     = 32'(HEIGHT / 2) - $signed({20'd0, py});
  assign ux_c   = dx * $signed(INV_H);
  assign uy_c   = dy * $signed(INV_H);
  assign sqx    = 48'(ux_c) * 48'(ux_c);
  assign sqy    = 48'(uy_c) * 48'(uy_c);
  assign len2_c = sqx[47:16] + sqy[47:16] + 32'h0001_0000;

  // Restoring square root step: bring down two radicand bits per cycle.
  logic [27:0] sq_rem_sh, sq_trial, sq_diff;
  logic        sq_ge;
  assign sq_rem_sh = {sq_rem, sq_rad[47:46]};
  assign sq_trial  = {2'b00, root, 2'b01};
  assign sq_ge     = (sq_rem_sh >= sq_trial);
  assign sq_diff   = sq_rem_sh - sq_trial;

  // Restoring divide of 2^32 by root. The dividend's bit 32 is preloaded as
  // the initial remainder (quotient bit 32 is always 0 because root > 1), so
  // only the 32 zero bits below it remain to be shifted in.
  logic [24:0] dv_sh, dv_diff;
  logic        dv_ge;
  assign dv_sh   = {dv_rem, 1'b0};
  assign dv_ge   = (dv_sh >= {1'b0, root});
  assign dv_diff = dv_sh - {1'b0, root};

  // Scale by the reciprocal; quot <= 0x10000 so it is positive as signed.
  logic signed [47:0] qs, pxp, pyp;
  assign qs  = $signed({16'd0, quot});
  assign pxp = 48'(ux) * qs;
  assign pyp = 48'(uy) * qs;

  logic unused_ok;
  assign unused_ok = ^{sqx[15:0], sqy[15:0], pxp[15:0], pyp[15:0],
                       sq_diff[27:26], dv_diff[24]};

  assign ray_valid = (state == S_OUT);
  assign last      = ray_valid && (px == 12'(WIDTH - 1)) && (py == 12'(HEIGHT - 1));
  assign ro        = ray_valid ? {CAM_X, CAM_Y, CAM_Z} : 96'd0;
  assign rd        = {rd_x, rd_y, rd_z};
  assign pix_x     = px;
  assign pix_y     = py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      px         <= '0;
      py         <= '0;
      ux         <= '0;
      uy         <= '0;
      sq_rad     <= '0;
      sq_rem     <= '0;
      root       <= '0;
      dv_rem     <= '0;
      quot       <= '0;
      cnt        <= '0;
      rd_x       <= '0;
      rd_y       <= '0;
      rd_z       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // frame_done high means IDLE was just entered; wait one cycle.
          if (start && !frame_done) begin
            px    <= '0;
            py    <= '0;
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          ux     <= ux_c;
          uy     <= uy_c;
          sq_rad <= {len2_c, 16'd0};
          sq_rem <= '0;
          root   <= '0;
          cnt    <= '0;
          state  <= S_SQRT;
        end
        S_SQRT: begin
          sq_rad <= {sq_rad[45:0], 2'b00};
          sq_rem <= sq_ge ? sq_diff[25:0] : sq_rem_sh[25:0];
          root   <= {root[22:0], sq_ge};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt    <= '0;
            dv_rem <= 24'd1;
            quot   <= '0;
            state  <= S_RECIP;
          end
        end
        S_RECIP: begin
          dv_rem <= dv_ge ? dv_diff[23:0] : dv_sh[23:0];
          quot   <= {quot[30:0], dv_ge};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            cnt   <= '0;
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          rd_x  <= pxp[47:16];
          rd_y  <= pyp[47:16];
          rd_z  <= quot;  // uz is exactly 1.0, so (uz*INV)>>>16 == INV
          state <= S_OUT;
        end
        S_OUT: begin
          if (ray_ready) begin
            if (last) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              if (px == 12'(WIDTH - 1)) begin
                px <= '0;
                py <= py + 12'd1;
              end else begin
                px <= px + 12'd1;
              end
              state <= S_SETUP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_generator.sv
module tb_ray_generator;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int INVH = 16384;
  localparam logic [95:0] RO_EXP = {32'h0000_0000, 32'h0001_0000, 32'hFFFD_0000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ray_ready = 1'b0;
  logic        busy, ray_valid, last, frame_done;
  logic [95:0] ro, rd;
  logic [11:0] pix_x, pix_y;

  ray_generator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ro(ro), .rd(rd),
    .pix_x(pix_x), .pix_y(pix_y), .last(last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          px;
    int          py;
    logic        lst;
    logic [95:0] rd;
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];
  int   hs_cyc[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   hs_cnt = 0;
  int   fd_cnt = 0;
  int   fd_cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference: bisection-style square root and a plain integer divide.
  function automatic logic [95:0] model_rd(input int x, input int y);
    longint ux, uy, len2, rad, l, t, inv, rx, ry;
    ux   = longint'(x - W / 2) * longint'(INVH);
    uy   = longint'(H / 2 - y) * longint'(INVH);
    len2 = ((ux * ux) >>> 16) + ((uy * uy) >>> 16) + 65536;
    rad  = len2 <<< 16;
    l    = 0;
    for (int b = 23; b >= 0; b--) begin
      t = l | (longint'(1) <<< b);
      if (t * t <= rad) l = t;
    end
    inv = (longint'(1) <<< 32) / l;
    rx  = (ux * inv) >>> 16;
    ry  = (uy * inv) >>> 16;
    return {32'(rx), 32'(ry), 32'(inv)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a valid&ready seen here is a handshake on the next edge.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n && ray_valid && ray_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ray: got pix (%0d,%0d), want no ray", pix_x, pix_y);
      end else begin
        e = sb.pop_front();
        check("pix_x", 96'(pix_x), 96'(e.px));
        check("pix_y", 96'(pix_y), 96'(e.py));
        check("last", 96'(last), 96'(e.lst));
        check("rd", rd, e.rd);
        check("ro", ro, RO_EXP);
      end
    end
    if (rst_n && frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      check("busy_at_frame_done", 96'(busy), 96'd0);
    end
  end

  task automatic push_frame();
    for (int i = 0; i < 16; i++) sb.push_back(tbl[i]);
  endtask

  task automatic do_start();
    int n;
    @(negedge clk);
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 96'(busy), 96'd1);
    n = 0;
    while (!ray_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("first_ray_latency", 96'(n), 96'd58);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      n_chk++;
      $display("FAIL frame_done_timeout: got no frame_done in %0d cycles, want pulse", n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 96'(busy), 96'd0);
    check({tag, "_valid"}, 96'(ray_valid), 96'd0);
    check({tag, "_last"}, 96'(last), 96'd0);
    check({tag, "_frame_done"}, 96'(frame_done), 96'd0);
    check({tag, "_rd"}, rd, 96'd0);
    check({tag, "_pix"}, {72'd0, pix_x, pix_y}, 96'd0);
    check({tag, "_ro"}, ro, 96'd0);
  endtask

  initial begin
    int          n;
    int          changes;
    logic [95:0] snap_rd;
    logic [23:0] snap_pix;

    for (int i = 0; i < 16; i++) begin
      tbl[i].px  = i % W;
      tbl[i].py  = i / W;
      tbl[i].lst = (i == 15);
      tbl[i].rd  = model_rd(i % W, i / W);
    end
    tbl[0].rd  = {32'hFFFF_977D, 32'h0000_6883, 32'h0000_D106};
    tbl[10].rd = {32'h0000_0000, 32'h0000_0000, 32'h0001_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Frame 1: ready tied high
    ray_ready = 1'b1;
    hs_cnt = 0; fd_cnt = 0; hs_cyc.delete();
    do_start();
    wait_frame_done();
    // start during the frame_done cycle must be ignored
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_in_done_cycle_busy", 96'(busy), 96'd0);
    repeat (3) @(posedge clk);
    #1 check("idle_valid", 96'(ray_valid), 96'd0);
    check("f1_handshakes", 96'(hs_cnt), 96'd16);
    check("f1_frame_done_count", 96'(fd_cnt), 96'd1);
    check("f1_sb_empty", 96'(sb.size()), 96'd0);
    if (hs_cyc.size() >= 16) begin
      check("throughput", 96'(hs_cyc[1] - hs_cyc[0]), 96'd59);
      check("frame_done_delay", 96'(fd_cyc - hs_cyc[15]), 96'd1);
    end else begin
      n_chk++;
      $display("FAIL f1_hs_log: got %0d handshakes logged, want 16", hs_cyc.size());
    end

    // Frame 2: backpressure on ray 0 plus start pulses while busy
    ray_ready = 1'b0;
    hs_cnt = 0; fd_cnt = 0;
    do_start();
    snap_rd  = rd;
    snap_pix = {pix_x, pix_y};
    changes  = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 7);
      @(posedge clk);
      #1 if (!ray_valid || rd !== snap_rd || {pix_x, pix_y} !== snap_pix) changes++;
    end
    start = 1'b0;
    check("bp_hold", 96'(changes), 96'd0);
    check("bp_rd", snap_rd, tbl[0].rd);
    ray_ready = 1'b1;
    n = 0;
    while (hs_cnt < 7 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_frame_done();
    repeat (2) @(posedge clk);
    check("f2_handshakes", 96'(hs_cnt), 96'd16);
    check("f2_sb_empty", 96'(sb.size()), 96'd0);

    // Frame 3: reset during SQRT of ray 5, then restart from (0,0)
    hs_cnt = 0; fd_cnt = 0;
    do_start();
    n = 0;
    while (hs_cnt < 5 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("f3_reached_ray5", 96'(hs_cnt), 96'd5);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    hs_cnt = 0; fd_cnt = 0;
    do_start();
    wait_frame_done();
    repeat (2) @(posedge clk);
    check("f3_handshakes", 96'(hs_cnt), 96'd16);
    check("f3_sb_empty", 96'(sb.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
